mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles to wait for bus_ack_i (range 1..65535).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the address width; data width is fixed at 32.
REQ-003 The block SHALL have these ports, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous, active-high reset
 req_valid_i  in  1  MEM stage holds a memory op
 op_i  in  4  op code: LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC
 addr_i  in  ADDR_W  effective byte address
 wdata_i  in  32  store data (reg2)
 flush_i  in  1  pipeline flush
 stall_o  out  1  hold upstream stages
 rdata_o  out  32  formatted load result / SC result
 rdata_valid_o  out  1  rdata_o is valid this cycle
 except_o  out  2  0 none, 1 AdEL, 2 AdES, 3 bus error
 badvaddr_o  out  ADDR_W  faulting address
 bus_req_o, bus_we_o  out  1 each  bus request, write
 bus_sel_o  out  4  byte enables, big-endian (addr 00 -> 1000)
 bus_addr_o  out  ADDR_W  word-aligned address
 bus_wdata_o  out  32  lane-replicated store data
 bus_ack_i  in  1  transfer complete
 bus_rdata_i  in  32  read word, valid with ack

Function
REQ-004 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-005 Alignment check SHALL be combinational in IDLE: LH/LHU/SH with addr[0]=1, or LW/LL/SW/SC with addr[1:0]!=0, raises except_o (AdEL for loads/LL, AdES for stores/SC) and badvaddr_o=addr_i in the same cycle, with no bus access and no stall.
REQ-006 In IDLE with req_valid_i=1, flush_i=0, no fault, and not an unlinked SC, the block SHALL assert stall_o combinationally, register addr/sel/wdata/op, and enter BUSY.
REQ-007 In BUSY, bus_req_o SHALL be 1 and bus_addr_o, bus_sel_o, bus_we_o, bus_wdata_o SHALL be stable until the cycle bus_ack_i=1; stall_o SHALL be 1.
REQ-008 On bus_ack_i in BUSY, the block SHALL capture the byte/halfword/word from bus_rdata_i (sign- or zero-extended per op) and enter DONE; minimum op latency is 2 cycles of stall.
REQ-009 DONE SHALL last one cycle with stall_o=0, rdata_valid_o=1 for loads/LL/SC, then return to IDLE; req_valid_i in DONE SHALL be ignored.
REQ-010 The BUSY cycle counter SHALL reach TIMEOUT without ack, then drop bus_req_o, set except_o=3, set badvaddr_o=registered address, and enter DONE with rdata_valid_o=0.
REQ-011 The link bit SHALL be set when LL completes and cleared by SC completion, any except_o!=0, flush_i, or rst.
REQ-012 SC with link=0 SHALL complete in IDLE in one cycle: no bus access, no stall, rdata_o=0, rdata_valid_o=1.
REQ-013 SC with link=1 SHALL perform a SW transfer and return rdata_o=1 in DONE.
REQ-014 flush_i in IDLE SHALL suppress any new request, and flush_i overrides req_valid_i.
REQ-015 flush_i in BUSY SHALL set a discard flag: the bus transfer completes, and on ack the block returns to IDLE directly with rdata_valid_o=0 and no link set.
REQ-016 Outside the conditions above, rdata_valid_o, except_o, bus_req_o, and stall_o SHALL be 0.

Reset
REQ-017 On rst, the block SHALL enter IDLE and clear the counter, link, discard flag, and registered fields to 0 on the next edge.
REQ-018 rst mid-BUSY SHALL drop bus_req_o the following cycle, and any late ack SHALL be ignored.
REQ-019 All outputs SHALL be 0 during reset.

Structure
REQ-020 The op encodings, the except_o codes, and the state encodings SHALL reside in the shared defines.v.
REQ-021 Lane select, store replication, and load extraction/extension SHALL be one combinational sub-module, lsu_lane_fmt.

Verification
REQ-022 The bench SHALL cover LB at 0x1001 with bus_rdata_i=0x12F45678 and ack after 3 cycles -> stall 4 cycles, bus_sel_o=0100, rdata_o=0xFFFFFFF4.
REQ-023 The bench SHALL cover LW at 0x1002 -> except_o=1, badvaddr_o=0x1002, bus_req_o never 1, stall_o=0.
REQ-024 The bench SHALL cover SH at 0x2002 with wdata 0xAAAA5555 -> bus_sel_o=0011, bus_wdata_o=0x55555555, bus_we_o=1.
REQ-025 The bench SHALL cover LL at 0x3000, then SC at 0x3000 -> SC bus write, rdata_o=1; a second SC -> no bus access, rdata_o=0.
REQ-026 The bench SHALL cover TIMEOUT=4 with no ack -> bus_req_o high for 4 cycles, then except_o=3 for one cycle.
REQ-027 The bench SHALL cover flush_i in BUSY of LW followed by ack -> rdata_valid_o stays 0, FSM returns to IDLE next cycle.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared op codes, exception codes and FSM states for the load/store unit.
// Also small op-classification helpers used by the control logic.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7,
    OP_LL  = 4'd8,
    OP_SC  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_ADEL = 2'd1,
    EXC_ADES = 2'd2,
    EXC_BUS  = 2'd3
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LW) || (op == OP_LL);
  endfunction

  function automatic logic misaligned(
    input logic [3:0] op,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
      r = off[0];
    else if ((op == OP_LW) || (op == OP_LL) ||
             (op == OP_SW) || (op == OP_SC))
      r = (off != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_lane_fmt.sv
// Big-endian lane select, store replication and load extraction/extension.
// Purely combinational; shared by request setup and response capture.
module lsu_lane_fmt
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic [3:0]  bsel;
  logic [3:0]  hsel;

  always_comb begin
    byte_w = 8'h00;
    unique case (off_i)
      2'd0: byte_w = rdata_i[31:24];
      2'd1: byte_w = rdata_i[23:16];
      2'd2: byte_w = rdata_i[15:8];
      2'd3: byte_w = rdata_i[7:0];
    endcase
    half_w = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    bsel   = 4'b1000 >> off_i;
    hsel   = off_i[1] ? 4'b0011 : 4'b1100;

    sel_o   = 4'b1111;
    wdata_o = wdata_i;
    load_o  = 32'h0;
    case (op_i)
      OP_LB: begin
        sel_o  = bsel;
        load_o = {{24{byte_w[7]}}, byte_w};
      end
      OP_LBU: begin
        sel_o  = bsel;
        load_o = {24'h0, byte_w};
      end
      OP_SB: begin
        sel_o   = bsel;
        wdata_o = {4{wdata_i[7:0]}};
      end
      OP_LH: begin
        sel_o  = hsel;
        load_o = {{16{half_w[15]}}, half_w};
      end
      OP_LHU: begin
        sel_o  = hsel;
        load_o = {16'h0, half_w};
      end
      OP_SH: begin
        sel_o   = hsel;
        wdata_o = {2{wdata_i[15:0]}};
      end
      OP_LW, OP_LL: load_o = rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: alignment check, single-outstanding bus
// transfer with timeout, LL/SC link tracking and flush discard.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic [1:0]        except_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              link_q, link_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;

  logic [3:0]  fmt_op;
  logic [1:0]  fmt_off;
  logic [3:0]  fmt_sel;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;
  logic        accept;
  logic        fault;
  logic        op_ok;

  assign fmt_op  = (state_q == ST_IDLE) ? op_i : op_q;
  assign fmt_off = (state_q == ST_IDLE) ? addr_i[1:0] : addr_q[1:0];

  lsu_lane_fmt u_fmt (
    .op_i    (fmt_op),
    .off_i   (fmt_off),
    .wdata_i (wdata_i),
    .rdata_i (bus_rdata_i),
    .sel_o   (fmt_sel),
    .wdata_o (fmt_wdata),
    .load_o  (fmt_load)
  );

  assign accept = req_valid_i && !flush_i;
  assign fault  = misaligned(op_i, addr_i[1:0]);
  assign op_ok  = is_load(op_i) || is_store(op_i);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    link_d    = link_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    rdata_d   = rdata_q;
    exc_d     = exc_q;

    stall_o       = 1'b0;
    rdata_o       = 32'h0;
    rdata_valid_o = 1'b0;
    except_o      = EXC_NONE;
    badvaddr_o    = '0;
    bus_req_o     = 1'b0;
    bus_we_o      = 1'b0;
    bus_sel_o     = 4'b0000;
    bus_addr_o    = '0;
    bus_wdata_o   = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && op_ok) begin
          if (fault) begin
            except_o   = is_store(op_i) ? EXC_ADES : EXC_ADEL;
            badvaddr_o = addr_i;
            link_d     = 1'b0;
          end else if ((op_i == OP_SC) && !link_q) begin
            rdata_valid_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            state_d   = ST_BUSY;
            cnt_d     = 16'h0;
            discard_d = 1'b0;
            addr_d    = addr_i;
            sel_d     = fmt_sel;
            wdata_d   = fmt_wdata;
            op_d      = op_i;
          end
        end
      end
      ST_BUSY: begin
        stall_o     = 1'b1;
        bus_req_o   = 1'b1;
        bus_we_o    = is_store(op_q);
        bus_sel_o   = sel_q;
        bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        bus_wdata_o = wdata_q;
        if (flush_i) discard_d = 1'b1;
        if (bus_ack_i) begin
          if (discard_q || flush_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            exc_d   = EXC_NONE;
            rdata_d = (op_q == OP_SC) ? 32'h1 : fmt_load;
            if (op_q == OP_LL) link_d = 1'b1;
            if (op_q == OP_SC) link_d = 1'b0;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          exc_d   = EXC_BUS;
          link_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (exc_q != EXC_NONE) begin
          except_o   = exc_q;
          badvaddr_o = addr_q;
        end else if (is_load(op_q) || (op_q == OP_SC)) begin
          rdata_valid_o = 1'b1;
          rdata_o       = rdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) link_d = 1'b0;

    // Outputs are forced quiet while reset is held, whatever the state.
    if (rst) begin
      stall_o       = 1'b0;
      rdata_o       = 32'h0;
      rdata_valid_o = 1'b0;
      except_o      = EXC_NONE;
      badvaddr_o    = '0;
      bus_req_o     = 1'b0;
      bus_we_o      = 1'b0;
      bus_sel_o     = 4'b0000;
      bus_addr_o    = '0;
      bus_wdata_o   = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'h0;
      link_q    <= 1'b0;
      discard_q <= 1'b0;
      addr_q    <= '0;
      sel_q     <= 4'b0000;
      wdata_q   <= 32'h0;
      op_q      <= 4'h0;
      rdata_q   <= 32'h0;
      exc_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      link_q    <= link_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      rdata_q   <= rdata_d;
      exc_q     <= exc_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, LL/SC, alignment faults,
// bus timeout, flush and reset behaviour, checked with immediate asserts.
module tb_mem_lsu;

  localparam logic [3:0] LB  = 4'd0;
  localparam logic [3:0] LH  = 4'd2;
  localparam logic [3:0] LW  = 4'd4;
  localparam logic [3:0] SH  = 4'd6;
  localparam logic [3:0] LL  = 4'd8;
  localparam logic [3:0] SC  = 4'd9;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic [1:0]  except_o;
  logic [31:0] badvaddr_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_asrt = 0;
  int n_fail = 0;

  mem_lsu #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .op_i          (op_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .except_o      (except_o),
    .badvaddr_o    (badvaddr_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_sel_o     (bus_sel_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_ack_i     (bus_ack_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven after the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] wd);
    req_valid_i = 1'b1;
    op_i        = op;
    addr_i      = a;
    wdata_i     = wd;
  endtask

  task automatic idle_in();
    req_valid_i = 1'b0;
    op_i        = 4'h0;
    addr_i      = 32'h0;
    wdata_i     = 32'h0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    flush_i     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();

    // reset: outputs quiet even with a request presented
    cyc();
    req(LW, 32'h1000, 32'h0);
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_busreq", bus_req_o, 0);
    chk("rst_rvalid", rdata_valid_o, 0);
    chk("rst_except", except_o, 0);
    cyc();
    idle_in();
    rst = 1'b0;
    #1;
    chk("idle_stall", stall_o, 0);

    // LB 0x1001, ack on third BUSY cycle -> four stall cycles
    cyc();
    req(LB, 32'h1001, 32'h0);
    #1;
    chk("lb_stall0", stall_o, 1);
    chk("lb_busreq0", bus_req_o, 0);
    cyc();
    idle_in();
    #1;
    chk("lb_stall1", stall_o, 1);
    chk("lb_busreq1", bus_req_o, 1);
    chk("lb_sel", bus_sel_o, 32'h4);
    chk("lb_addr", bus_addr_o, 32'h1000);
    chk("lb_we", bus_we_o, 0);
    cyc();
    #1;
    chk("lb_stall2", stall_o, 1);
    cyc();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h12F45678;
    #1;
    chk("lb_stall3", stall_o, 1);
    cyc();
    idle_in();
    #1;
    chk("lb_done_stall", stall_o, 0);
    chk("lb_rvalid", rdata_valid_o, 1);
    chk("lb_rdata", rdata_o, 32'hFFFFFFF4);
    cyc();
    #1;
    chk("lb_after_rvalid", rdata_valid_o, 0);

    // LW misaligned -> AdEL, no stall, no bus
    cyc();
    req(LW, 32'h1002, 32'h0);
    #1;
    chk("adel_exc", except_o, 1);
    chk("adel_badv", badvaddr_o, 32'h1002);
    chk("adel_stall", stall_o, 0);
    chk("adel_busreq", bus_req_o, 0);
    cyc();
    idle_in();
    #1;
    chk("adel_busreq_next", bus_req_o, 0);
    chk("adel_exc_next", except_o, 0);

    // SH 0x2002 with immediate ack (minimum latency)
    cyc();
    req(SH, 32'h2002, 32'hAAAA5555);
    #1;
    chk("sh_stall0", stall_o, 1);
    cyc();
    idle_in();
    bus_ack_i = 1'b1;
    #1;
    chk("sh_sel", bus_sel_o, 32'h3);
    chk("sh_wdata", bus_wdata_o, 32'h55555555);
    chk("sh_we", bus_we_o, 1);
    chk("sh_addr", bus_addr_o, 32'h2000);
    cyc();
    idle_in();
    #1;
    chk("sh_done_stall", stall_o, 0);
    chk("sh_done_rvalid", rdata_valid_o, 0);

    // LH 0x9002 sign-extended from low half
    cyc();
    req(LH, 32'h9002, 32'h0);
    cyc();
    idle_in();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h12348001;
    #1;
    chk("lh_sel", bus_sel_o, 32'h3);
    cyc();
    idle_in();
    #1;
    chk("lh_rdata", rdata_o, 32'hFFFF8001);

    // LL then linked SC then unlinked SC
    cyc();
    req(LL, 32'h3000, 32'h0);
    cyc();
    idle_in();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hDEADBEEF;
    cyc();
    idle_in();
    #1;
    chk("ll_rvalid", rdata_valid_o, 1);
    chk("ll_rdata", rdata_o, 32'hDEADBEEF);
    cyc();
    req(SC, 32'h3000, 32'h11223344);
    #1;
    chk("sc1_stall", stall_o, 1);
    cyc();
    idle_in();
    bus_ack_i = 1'b1;
    #1;
    chk("sc1_busreq", bus_req_o, 1);
    chk("sc1_we", bus_we_o, 1);
    chk("sc1_sel", bus_sel_o, 32'hF);
    chk("sc1_wdata", bus_wdata_o, 32'h11223344);
    cyc();
    idle_in();
    #1;
    chk("sc1_rvalid", rdata_valid_o, 1);
    chk("sc1_rdata", rdata_o, 32'h1);
    cyc();
    req(SC, 32'h3000, 32'h55667788);
    #1;
    chk("sc2_stall", stall_o, 0);
    chk("sc2_busreq", bus_req_o, 0);
    chk("sc2_rvalid", rdata_valid_o, 1);
    chk("sc2_rdata", rdata_o, 32'h0);
    cyc();
    idle_in();
    #1;
    chk("sc2_busreq_next", bus_req_o, 0);

    // timeout: four BUSY cycles then bus error for one cycle
    cyc();
    req(LW, 32'h4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      idle_in();
      #1;
      chk($sformatf("to_busreq%0d", i), bus_req_o, 1);
    end
    cyc();
    #1;
    chk("to_busreq_drop", bus_req_o, 0);
    chk("to_exc", except_o, 3);
    chk("to_badv", badvaddr_o, 32'h4000);
    chk("to_rvalid", rdata_valid_o, 0);
    cyc();
    #1;
    chk("to_exc_clear", except_o, 0);

    // flush during BUSY: transfer completes, result dropped
    cyc();
    req(LW, 32'h5000, 32'h0);
    cyc();
    idle_in();
    flush_i = 1'b1;
    #1;
    chk("fl_busreq", bus_req_o, 1);
    cyc();
    idle_in();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hCAFEF00D;
    #1;
    chk("fl_busreq_hold", bus_req_o, 1);
    cyc();
    idle_in();
    req(LW, 32'h6000, 32'h0);
    #1;
    chk("fl_rvalid", rdata_valid_o, 0);
    chk("fl_idle_accept", stall_o, 1);
    cyc();
    idle_in();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h0BADF00D;
    cyc();
    idle_in();
    #1;
    chk("fl_next_rdata", rdata_o, 32'h0BADF00D);

    // flush in IDLE overrides request
    cyc();
    req(LW, 32'h7000, 32'h0);
    flush_i = 1'b1;
    #1;
    chk("fli_stall", stall_o, 0);
    cyc();
    idle_in();
    #1;
    chk("fli_busreq", bus_req_o, 0);

    // reset mid-BUSY, late ack ignored
    cyc();
    req(LW, 32'h8000, 32'h0);
    cyc();
    idle_in();
    #1;
    chk("rb_busreq", bus_req_o, 1);
    cyc();
    rst = 1'b1;
    #1;
    chk("rb_busreq_rst", bus_req_o, 0);
    cyc();
    rst       = 1'b0;
    bus_ack_i = 1'b1;
    #1;
    chk("rb_busreq_after", bus_req_o, 0);
    chk("rb_stall_after", stall_o, 0);
    cyc();
    idle_in();
    #1;
    chk("rb_rvalid", rdata_valid_o, 0);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
